// File: rtl/serial_operand_feeder.sv
// Bit-serial operand feeder: accepts an operand pair over valid/ready and shifts
// both operands out LSB-first, one bit pair per clock, with first/last markers.
module serial_operand_feeder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             stall,
  output logic             ser_valid,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_first,
  output logic             ser_last,
  output logic             word_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [CW-1:0]    cnt;
  logic             last_bit, consume, accept;

  assign last_bit = (state == SHIFT) && (cnt == CNT_LAST);
  assign consume  = last_bit && !stall;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (consume && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced low for the whole cycle whenever rst is high.
  always_comb begin
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    ser_a     = 1'b0;
    ser_b     = 1'b0;
    ser_first = 1'b0;
    ser_last  = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: in_ready = 1'b1;
        SHIFT: begin
          in_ready  = consume;
          ser_valid = 1'b1;
          ser_a     = sh_a[0];
          ser_b     = sh_b[0];
          ser_first = (cnt == '0);
          ser_last  = (cnt == CNT_LAST);
        end
        default: in_ready = 1'b0;
      endcase
    end
  end

  // Shift datapath; a completing word without a reload parks cnt at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a      <= '0;
      sh_b      <= '0;
      cnt       <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= consume;
      if (accept) begin
        sh_a <= op_a;
        sh_b <= op_b;
        cnt  <= '0;
      end else if ((state == SHIFT) && !stall) begin
        sh_a <= sh_a >> 1;
        sh_b <= sh_b >> 1;
        cnt  <= consume ? '0 : cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Scoreboard bench for serial_operand_feeder: stimulus queues expected bit pairs,
// a negedge monitor compares every presented bit pair and word_done pulse.
module tb_serial_operand_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] op_a = 8'h00;
  logic [7:0] op_b = 8'h00;
  logic       stall = 1'b0;
  logic       ser_valid, ser_a, ser_b, ser_first, ser_last, word_done;

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_q[$];
  logic exp_done = 1'b0;
  int run = 0;
  int max_run = 0;

  serial_operand_feeder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .stall(stall),
    .ser_valid(ser_valid), .ser_a(ser_a), .ser_b(ser_b),
    .ser_first(ser_first), .ser_last(ser_last), .word_done(word_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    for (int i = 0; i < 8; i++) exp_q.push_back({a[i], b[i], i == 0, i == 7});
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    while (!in_ready && n < 200) begin
      step;
      n++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    step;
    in_valid = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    while ((exp_q.size() != 0 || ser_valid) && n < 200) begin
      step;
      n++;
    end
    check("drain_complete", {31'd0, (exp_q.size() == 0) && !ser_valid}, 32'd1);
    step;
  endtask

  // Monitor: pop one expected bit pair per consumed (non-stalled) output cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (ser_valid) begin
        run++;
        if (run > max_run) max_run = run;
        if (exp_q.size() == 0) check("unexpected_bit", {28'd0, ser_a, ser_b, ser_first, ser_last}, 32'hF0);
        else begin
          check("bit_pair", {28'd0, ser_a, ser_b, ser_first, ser_last}, {28'd0, exp_q[0]});
          if (!stall) void'(exp_q.pop_front());
        end
      end else run = 0;
      if (word_done || exp_done) check("word_done", {31'd0, word_done}, {31'd0, exp_done});
      exp_done = ser_valid && ser_last && !stall;
    end else begin
      run = 0;
      exp_done = 1'b0;
    end
  end

  initial begin
    // Test 1: reset
    step;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_outputs", {26'd0, ser_valid, ser_a, ser_b, ser_first, ser_last, word_done}, 32'd0);
    step;
    check("rst_in_ready2", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_valid", {31'd0, ser_valid}, 32'd0);

    // Test 2: single word 0x35/0x0F
    send(8'h35, 8'h0F);
    repeat (6) step;
    check("t2_ready_c7", {31'd0, in_ready}, 32'd0);
    step;
    check("t2_ready_c8", {31'd0, in_ready}, 32'd1);
    step;
    check("t2_done_c9", {31'd0, word_done}, 32'd1);
    check("t2_idle_c9", {30'd0, ser_valid, in_ready}, 32'd1);
    check("t2_queue_empty", exp_q.size(), 32'd0);
    step;

    // Test 3: back-to-back words
    max_run = 0;
    send(8'hFF, 8'h01);
    send(8'h80, 8'h80);
    drain;
    check("t3_contig_run", max_run, 32'd16);

    // Test 4: stall on bit 2 for 3 cycles, then on bit 7
    send(8'hA5, 8'h5A);
    step;
    step;
    stall = 1'b1;
    check("t4_bit2", {30'd0, ser_a, ser_b}, 32'd2);
    repeat (3) step;
    stall = 1'b0;
    check("t4_bit2_held", {30'd0, ser_a, ser_b}, 32'd2);
    repeat (5) step;
    check("t4_at_last", {31'd0, ser_last}, 32'd1);
    stall = 1'b1;
    #1;
    check("t4_stall_ready0", {31'd0, in_ready}, 32'd0);
    step;
    check("t4_stall_ready1", {31'd0, in_ready}, 32'd0);
    check("t4_no_done", {31'd0, word_done}, 32'd0);
    step;
    stall = 1'b0;
    #1;
    check("t4_release_ready", {31'd0, in_ready}, 32'd1);
    drain;

    // Test 5: in_valid pulse while busy is ignored
    send(8'h0C, 8'h03);
    repeat (4) step;
    in_valid = 1'b1;
    op_a = 8'h11;
    op_b = 8'h22;
    #1;
    check("t5_busy_ready", {31'd0, in_ready}, 32'd0);
    step;
    in_valid = 1'b0;
    drain;
    check("t5_idle", {30'd0, ser_valid, in_ready}, 32'd1);

    // Test 6: reset mid-word discards the word
    send(8'hF0, 8'h0F);
    repeat (5) step;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("t6_rst_outputs", {30'd0, ser_valid, in_ready}, 32'd0);
    step;
    rst = 1'b0;
    #1;
    check("t6_after_rst", {29'd0, ser_valid, word_done, in_ready}, 32'd1);
    repeat (10) step;
    check("t6_no_done", {31'd0, word_done}, 32'd0);
    send(8'h3C, 8'hC3);
    drain;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_operand_feeder.md
Name: serial_operand_feeder

Overview:
- Upstream stage for the bit-serial adder.
- Accepts two WIDTH-bit operands over a valid/ready handshake and shifts them out LSB-first, one bit pair per clk, on ser_a/ser_b.
- Emits ser_first so the adder clears its carry, and ser_last so the downstream collector closes the word.
- Supports back-to-back words with no bubble and a stall input that freezes the stream.

Parameters:
WIDTH, 8, operand width in bits; legal range is 2 or more. Counter width is $clog2(WIDTH).

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  reset, synchronous and active-high
in_valid  in  1  operand pair on op_a/op_b is valid
in_ready  out  1  feeder can accept an operand pair this cycle
op_a  in  WIDTH  operand A
op_b  in  WIDTH  operand B
stall  in  1  downstream hold; freezes the shift and the counter
ser_valid  out  1  ser_a/ser_b carry a live bit pair
ser_a  out  1  current bit of A, LSB first
ser_b  out  1  current bit of B, LSB first
ser_first  out  1  bit 0 of a word is on ser_a/ser_b
ser_last  out  1  bit WIDTH-1 of a word is on ser_a/ser_b
word_done  out  1  one-cycle pulse after the last bit pair is consumed

Behaviour:
- Reset:
  - While rst=1 at an edge: state goes to IDLE; shift registers, bit counter and word_done are cleared to 0.
  - in_ready, ser_valid, ser_a, ser_b, ser_first, ser_last are 0 during any cycle in which rst is high.
  - rst has priority over all other inputs.
  - Reset mid-word discards the word; there is no partial-word flush.
- States:
  - IDLE: in_ready=1; ser_* outputs are 0.
  - SHIFT: ser_valid=1; ser_a=sh_a[0]; ser_b=sh_b[0]; ser_first=(cnt==0); ser_last=(cnt==WIDTH-1).
- Accept:
  - A transfer occurs when in_valid and in_ready are both 1 at an edge.
  - The transfer loads sh_a<=op_a, sh_b<=op_b, cnt<=0, and moves the state to SHIFT.
  - Bit 0 is on the outputs in the cycle after the accepting edge (latency 1).
- Advance:
  - In SHIFT with stall=0, each edge shifts sh_a/sh_b right by 1 (zero fill) and increments cnt.
  - With stall=1, the shift registers, cnt, state and all ser_* outputs hold their values; ser_valid stays 1.
- End of word:
  - When cnt==WIDTH-1 and stall=0, the pair is consumed at the edge. Next state is IDLE unless a new transfer occurs on that same edge.
  - word_done is a registered 1-cycle pulse in the cycle after that edge.
- Back-to-back:
  - in_ready = (state==IDLE) OR (state==SHIFT AND cnt==WIDTH-1 AND stall==0).
  - A transfer on the last-bit edge reloads the shift registers, sets cnt=0 and stays in SHIFT.
  - Bit 0 of the new word follows bit WIDTH-1 of the old word directly, so ser_first follows ser_last with no gap.
  - Sustained throughput is one word per WIDTH cycles.
- Handshake rules:
  - in_valid asserted while in_ready=0 is ignored; operands are not latched.
  - The upstream must hold op_a/op_b until the transfer occurs.
  - in_ready is a combinational function of state, cnt and stall only; it never depends on in_valid.
- Stall boundaries:
  - stall in IDLE has no effect.
  - stall on the last bit blocks both completion and back-to-back accept; word_done is delayed accordingly.
- Counter: never exceeds WIDTH-1. No wrap except via reload to 0.

Test Plan:
1. WIDTH=8, rst high for 2 cycles → all outputs 0 and in_ready=0 while rst is high; after release, in_ready=1 and ser_valid=0.
2. Accept op_a=0x35, op_b=0x0F with stall=0 → over the next 8 cycles ser_a=1,0,1,0,1,1,0,0 and ser_b=1,1,1,1,0,0,0,0. ser_first=1 only on cycle 1, ser_last=1 only on cycle 8, word_done=1 on cycle 9, in_ready=1 from cycle 8.
3. Back-to-back: hold in_valid=1 with 0xFF/0x01, then 0x80/0x80 → 16 contiguous ser_valid cycles. ser_last (cycle 8) is immediately followed by ser_first (cycle 9). Second word ser_a=0,0,0,0,0,0,0,1.
4. Stall: 0xA5/0x5A, stall=1 for 3 cycles while bit 2 is on the outputs → ser_a=1 and ser_b=0 hold for 4 cycles total. The word completes 3 cycles late. Stall on bit 7 holds in_ready=0 for its duration.
5. in_valid pulsed with 0x11/0x22 during bit 4 of a 0x0C/0x03 word → ignored; the stream completes 0x0C/0x03 unchanged and returns to IDLE.
6. rst asserted at bit 5 of 0xF0/0x0F → next cycle ser_valid=0, state IDLE, word_done never pulses; a fresh accept afterwards streams correctly from bit 0.
